// File: rtl/mxv_loop_iter_gen_if.sv
// Decode/config and event bundle between instruction decode, the MXV loop-nest
// sequencer, and the downstream obuf-bias select and address generators.
interface mxv_loop_iter_gen_if #(
    parameter int LOOP_ID_W = 5,
    parameter int ITER_W    = 16
);
    logic                 done;
    logic                 cfg_loop_iter_v;
    logic [ITER_W-1:0]    cfg_loop_iter;
    logic                 start;
    logic                 stall;
    logic                 ready;
    logic [LOOP_ID_W:0]   num_loops;
    logic                 iter_v;
    logic                 loop_exit;
    logic [LOOP_ID_W-1:0] loop_index;
    logic                 compute_done;
    logic                 cfg_overflow;

    modport master (
        output done, cfg_loop_iter_v, cfg_loop_iter, start, stall,
        input  ready, num_loops, iter_v, loop_exit, loop_index, compute_done, cfg_overflow
    );

    modport slave (
        input  done, cfg_loop_iter_v, cfg_loop_iter, start, stall,
        output ready, num_loops, iter_v, loop_exit, loop_index, compute_done, cfg_overflow
    );
endinterface

// File: rtl/mxv_loop_iter_gen.sv
// MXV compute-side loop-nest sequencer: holds per-loop trip counts, steps the nest
// once per un-stalled cycle and emits registered loop-exit / compute-done events.
module mxv_loop_iter_gen #(
    parameter int LOOP_ID_W = 5,
    parameter int ITER_W    = 16
) (
    input logic                clk,
    input logic                reset,
    mxv_loop_iter_gen_if.slave bus
);
    localparam int MAX_LOOPS = 2 ** LOOP_ID_W;

    typedef logic [LOOP_ID_W:0]   nl_t;
    typedef logic [LOOP_ID_W-1:0] li_t;
    typedef logic [ITER_W-1:0]    it_t;
    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    nl_t                  num_loops;
    it_t                  iter_tbl [MAX_LOOPS];
    it_t                  cnt      [MAX_LOOPS];
    it_t                  cnt_nxt  [MAX_LOOPS];
    logic [MAX_LOOPS-1:0] wrap;
    li_t                  wrap_idx;
    logic                 last_step;
    logic                 table_full;

    logic                 iter_v_q;
    logic                 loop_exit_q;
    li_t                  loop_index_q;
    logic                 compute_done_q;
    logic                 cfg_overflow_q;

    assign table_full = (num_loops == nl_t'(MAX_LOOPS));

    // Ripple carry: loop i wraps only when every inner loop is also at its max.
    always_comb begin
        logic carry;
        carry     = 1'b1;
        wrap      = '0;
        wrap_idx  = '0;
        last_step = 1'b0;
        for (int unsigned i = 0; i < MAX_LOOPS; i++) begin
            cnt_nxt[i] = cnt[i];
            if (nl_t'(i) < num_loops) begin
                wrap[i] = carry && (cnt[i] == iter_tbl[i]);
                if (wrap[i]) begin
                    cnt_nxt[i] = '0;
                    wrap_idx   = li_t'(i);
                    last_step  = (nl_t'(i + 1) == num_loops);
                end else if (carry) begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
            carry = wrap[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            num_loops      <= '0;
            iter_v_q       <= 1'b0;
            loop_exit_q    <= 1'b0;
            loop_index_q   <= '0;
            compute_done_q <= 1'b0;
            cfg_overflow_q <= 1'b0;
            for (int unsigned i = 0; i < MAX_LOOPS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            iter_v_q       <= 1'b0;
            loop_exit_q    <= 1'b0;
            loop_index_q   <= '0;
            compute_done_q <= 1'b0;
            cfg_overflow_q <= 1'b0;

            if (bus.done) begin
                // Abort dominates start, cfg writes and stepping alike.
                state     <= IDLE;
                num_loops <= '0;
                for (int unsigned i = 0; i < MAX_LOOPS; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.cfg_loop_iter_v) begin
                            if (!table_full) begin
                                iter_tbl[num_loops[LOOP_ID_W-1:0]] <= bus.cfg_loop_iter;
                                num_loops <= num_loops + 1'b1;
                            end else begin
                                cfg_overflow_q <= 1'b1;
                            end
                        end
                        if (bus.start) begin
                            if (num_loops != '0) begin
                                state <= BUSY;
                            end else begin
                                compute_done_q <= 1'b1;
                            end
                        end
                    end

                    BUSY: begin
                        if (bus.cfg_loop_iter_v) begin
                            cfg_overflow_q <= 1'b1;
                        end
                        if (!bus.stall) begin
                            iter_v_q     <= 1'b1;
                            loop_exit_q  <= wrap[0];
                            loop_index_q <= wrap[0] ? wrap_idx : '0;
                            for (int unsigned i = 0; i < MAX_LOOPS; i++) begin
                                cnt[i] <= cnt_nxt[i];
                            end
                            if (last_step) begin
                                compute_done_q <= 1'b1;
                                state          <= IDLE;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ready        = (state == IDLE);
    assign bus.num_loops    = num_loops;
    assign bus.iter_v       = iter_v_q;
    assign bus.loop_exit    = loop_exit_q;
    assign bus.loop_index   = loop_index_q;
    assign bus.compute_done = compute_done_q;
    assign bus.cfg_overflow = cfg_overflow_q;
endmodule

// File: tb/tb_mxv_loop_iter_gen.sv
// Scoreboard bench for mxv_loop_iter_gen: a mixed-radix model of the loop nest
// queues the expected event stream; a negedge monitor pops and compares.
module tb_mxv_loop_iter_gen;
    localparam int LOOP_ID_W = 5;
    localparam int ITER_W    = 16;
    localparam int MAXL      = 2 ** LOOP_ID_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mxv_loop_iter_gen_if #(.LOOP_ID_W(LOOP_ID_W), .ITER_W(ITER_W)) bus ();

    mxv_loop_iter_gen #(.LOOP_ID_W(LOOP_ID_W), .ITER_W(ITER_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit iv;
        bit ex;
        int idx;
        bit cd;
    } ev_t;

    ev_t exp_q[$];
    int  mdl_tbl[$];
    int  checks     = 0;
    int  errors     = 0;
    int  popped     = 0;
    int  stall_mode = 0;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Iteration n (0-based) closes loop j when (n+1) is a multiple of prod_{k<=j}(iter[k]+1).
    task automatic push_run();
        ev_t    e;
        longint total;
        longint prod;
        if (mdl_tbl.size() == 0) begin
            e = '{iv: 1'b0, ex: 1'b0, idx: 0, cd: 1'b1};
            exp_q.push_back(e);
        end else begin
            total = 1;
            foreach (mdl_tbl[k]) total = total * (mdl_tbl[k] + 1);
            for (longint n = 0; n < total; n++) begin
                e    = '{iv: 1'b1, ex: 1'b0, idx: 0, cd: (n == total - 1)};
                prod = 1;
                for (int j = 0; j < mdl_tbl.size(); j++) begin
                    prod = prod * (mdl_tbl[j] + 1);
                    if ((n + 1) % prod == 0) begin
                        e.ex  = 1'b1;
                        e.idx = j;
                    end
                end
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (bus.iter_v || bus.loop_exit || bus.compute_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got iter_v=%0b loop_exit=%0b compute_done=%0b, required no event",
                         bus.iter_v, bus.loop_exit, bus.compute_done);
            end else begin
                e = exp_q.pop_front();
                popped++;
                if (bus.iter_v !== e.iv || bus.loop_exit !== e.ex || bus.compute_done !== e.cd ||
                    (e.ex && int'(bus.loop_index) != e.idx) || (e.cd && bus.ready !== 1'b1)) begin
                    errors++;
                    $display("FAIL event_%0d: got iv=%0b ex=%0b idx=%0d cd=%0b rdy=%0b, required iv=%0b ex=%0b idx=%0d cd=%0b rdy=1",
                             popped, bus.iter_v, bus.loop_exit, bus.loop_index, bus.compute_done, bus.ready,
                             e.iv, e.ex, e.idx, e.cd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        exp_q.delete();
        mdl_tbl.delete();
    endtask

    task automatic cfg_write(input int val, input bit busy);
        bit ovf;
        ovf = busy || (mdl_tbl.size() >= MAXL);
        bus.cfg_loop_iter_v = 1'b1;
        bus.cfg_loop_iter   = 16'(val);
        tick();
        bus.cfg_loop_iter_v = 1'b0;
        check("cfg_overflow", bus.cfg_overflow, ovf);
        if (!ovf) mdl_tbl.push_back(val);
        check("num_loops", bus.num_loops, mdl_tbl.size());
    endtask

    task automatic do_start();
        push_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (stall_mode == 1)      bus.stall = ~bus.stall;
            else if (stall_mode == 2) bus.stall = 1'($urandom_range(0, 1));
            else                      bus.stall = 1'b0;
            tick();
            if (bus.ready && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        bus.stall = 1'b0;
        check("run_completes", ok, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        reset               = 1'b1;
        bus.done            = 1'b0;
        bus.cfg_loop_iter_v = 1'b0;
        bus.cfg_loop_iter   = '0;
        bus.start           = 1'b0;
        bus.stall           = 1'b0;
        repeat (3) tick();
        check("reset_ready", bus.ready, 1);
        check("reset_num_loops", bus.num_loops, 0);
        check("reset_iter_v", bus.iter_v, 0);
        check("reset_compute_done", bus.compute_done, 0);
        reset = 1'b0;
        tick();

        // 2x3 nest
        cfg_write(1, 0);
        cfg_write(2, 0);
        do_start();
        check("busy_not_ready", bus.ready, 0);
        wait_idle(100);

        // {0,0,3}: every step exits
        clear_all();
        cfg_write(0, 0);
        cfg_write(0, 0);
        cfg_write(3, 0);
        do_start();
        wait_idle(100);

        // 2x3 nest with alternating stall
        clear_all();
        cfg_write(1, 0);
        cfg_write(2, 0);
        stall_mode = 1;
        do_start();
        wait_idle(100);
        stall_mode = 0;

        // Fill the table, then overflow it
        clear_all();
        for (int i = 0; i < MAXL; i++) cfg_write((i < 3) ? int'($urandom_range(0, 1)) : 0, 0);
        cfg_write(5, 0);
        do_start();
        wait_idle(200);

        // Write while BUSY is dropped
        clear_all();
        cfg_write(2, 0);
        cfg_write(1, 0);
        do_start();
        cfg_write(7, 1);
        wait_idle(100);
        check("num_loops_after_busy_write", bus.num_loops, 2);

        // Abort with done after 5 steps
        clear_all();
        cfg_write(3, 0);
        cfg_write(3, 0);
        p0 = popped;
        do_start();
        repeat (5) tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("abort_events_seen", popped - p0, 5);
        exp_q.delete();
        mdl_tbl.delete();
        check("abort_ready", bus.ready, 1);
        check("abort_num_loops", bus.num_loops, 0);
        check("abort_compute_done", bus.compute_done, 0);
        do_start();
        wait_idle(50);

        // Randomized nests with random stall
        for (int r = 0; r < 8; r++) begin
            int depth;
            clear_all();
            depth = int'($urandom_range(1, 3));
            for (int d = 0; d < depth; d++) cfg_write(int'($urandom_range(0, 3)), 0);
            stall_mode = 2;
            do_start();
            wait_idle(1000);
            stall_mode = 0;
        end

        // Reset mid-run
        clear_all();
        cfg_write(3, 0);
        cfg_write(3, 0);
        do_start();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        mdl_tbl.delete();
        check("midreset_ready", bus.ready, 1);
        check("midreset_num_loops", bus.num_loops, 0);
        check("midreset_iter_v", bus.iter_v, 0);
        check("midreset_loop_exit", bus.loop_exit, 0);
        check("midreset_compute_done", bus.compute_done, 0);
        check("midreset_cfg_overflow", bus.cfg_overflow, 0);
        reset = 1'b0;
        tick();
        check("after_reset_quiet", bus.iter_v, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
